muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
// - Sequencer for a shared iterative multiply/divide unit feeding HI/LO in the 5-stage static pipeline.
// - Accepts mult/multu/div/divu from EX and runs a 32-step shift-add or restoring-subtract core.
// - Raises stall so pcreg, IF_ID and ID_EX hold; this stall is ORed with the ID hazard stall.
// - Presents the 64-bit result as hi/lo with a one-cycle done pulse for the HI/LO writeback path.
// PARAMETERS
// - WIDTH  32  operand width; hi/lo are WIDTH bits each.
// - ITERS  32  CALC iterations; must equal WIDTH.
// PORTS
// - clk         in   1      system clock; single clock domain, all state on posedge.
// - rst         in   1      synchronous, active-high reset.
// - start       in   1      EX holds a mult/div instruction; level, held while stalled.
// - op          in   2      00 multu, 01 mult, 10 divu, 11 div.
// - a           in   WIDTH  rs operand: multiplicand or dividend.
// - b           in   WIDTH  rt operand: multiplier or divisor.
// - hilo_rd     in   1      ID holds mfhi/mflo/mthi/mtlo.
// - busy        out  1      state is neither IDLE nor DONE.
// - stall       out  1      combinational; freezes the front of the pipeline.
// - done        out  1      one-cycle pulse; hi/lo are new in that cycle.
// - hi          out  WIDTH  product[63:32], or remainder for div ops.
// - lo          out  WIDTH  product[31:0], or quotient for div ops.
// - div_by_zero out  1      held high in DONE when a div op had b==0.
// BEHAVIOUR
// - Reset values: state=IDLE; busy=0, stall=0, done=0, hi=0, lo=0, div_by_zero=0; iteration count=0.
// - States:
//   - IDLE -(start)-> CALC; divide op with b==0 goes IDLE->DONE instead.
//   - CALC -(count==ITERS-1)-> FIX -> DONE -> IDLE.
// - start is sampled only in IDLE; it is ignored in CALC, FIX and DONE.
//   - Consequence: a start still high in DONE cannot relaunch, because EX advances on that edge.
// - Leaving IDLE on start latches operands.
//   - Signed ops (op[0]=1) take |a| and |b|; |0x80000000| = 2^31 as unsigned.
//   - neg_q = a[31]^b[31]; neg_r = a[31]; both are 0 for unsigned ops.
// - CALC performs one core step per cycle; the count increments and wraps to 0 on FIX entry.
// - FIX edge: sign correction, then the hi/lo registers are written.
//   - Mult: 64-bit product negated when neg_q.
//   - Div: quotient negated when neg_q; remainder negated when neg_r.
// - Latency: start seen in cycle 0; CALC in cycles 1..32; FIX in 33; DONE (done=1) in 34.
//   - Divide by zero: DONE in cycle 1 with lo=0xFFFF_FFFF, hi=a unmodified, div_by_zero=1.
// - stall = (state==IDLE & start & ~dbz_now) | (state==CALC) | (state==FIX) | (hilo_rd & busy).
//   - stall is low in DONE, so the EX instruction retires in the same cycle hi/lo become valid.
//   - On the dbz path stall is low in cycle 0; hi/lo are consumed by a later mfhi/mflo, which sees DONE/IDLE.
// - hi and lo hold the last result until the next FIX or DONE write; they never clear except on reset.
// - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.
// - rst during any state forces the reset values on the next edge; the partial result is discarded.
// - done and div_by_zero are registered; hilo_rd has no effect in IDLE or DONE.
// STRUCTURE
// - Package muldiv_pkg holds:
//   - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
//   - state encoding S_IDLE/S_CALC/S_FIX/S_DONE (2 bits);
//   - ITERS default.
// - Sub-module muldiv_iter_core (combinational step) with inputs {acc_hi, acc_lo, divisor/multiplicand, is_div}.
//   - Mult step: conditional add on acc_lo[0], then shift right.
//   - Div step: shift left, trial subtract, set q bit.
// - muldiv_ctrl owns the FSM, counter, operand/sign registers and hi/lo output registers.
// TESTING
// - multu a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE lo=0x00000001; stall high cycles 0..33.
// - mult a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; div a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
// - divu a=100 b=7 -> lo=14 hi=2; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
// - divu a=5 b=0 -> done in cycle 1, lo=0xFFFFFFFF hi=5 div_by_zero=1; stall low throughout.
// - hilo_rd=1 from cycle 3 of a mult -> stall held to cycle 33 and low in 34; start kept high through DONE -> no relaunch.
// - rst at cycle 10 of a div -> next cycle busy=0 stall=0 hi=lo=0 done=0; new start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ITERS_DEFAULT = 32;

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational step of the shared core: shift-add multiply or restoring divide.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             is_div_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        add_sum  = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh   = {acc_hi_i, acc_lo_i[WIDTH-1]};
        trial    = rem_sh - {1'b0, opnd_i};
        acc_hi_o = add_sum[WIDTH:1];
        acc_lo_o = {add_sum[0], acc_lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            // Partial remainder stays below the divisor, so bit WIDTH of trial is a clean borrow flag.
            if (!trial[WIDTH]) begin
                acc_hi_o = trial[WIDTH-1:0];
                acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_o = rem_sh[WIDTH-1:0];
                acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative mult/div unit: FSM, operand latch, sign fix-up and HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(ITERS);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q;
    logic               is_div_q, neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_neg;
    logic               dbz_now, cnt_last;

    // Magnitude for signed ops; the most negative value maps to 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign dbz_now  = start && op[1] && (b == '0);
    assign cnt_last = (cnt_q == CNT_W'(ITERS - 1));

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    always_comb begin
        prod_neg = -{acc_hi_q, acc_lo_q};
        fix_hi   = acc_hi_q;
        fix_lo   = acc_lo_q;
        if (is_div_q) begin
            fix_lo = neg_quo_q ? -acc_lo_q : acc_lo_q;
            fix_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else if (neg_quo_q) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    if (start) begin
                        if (dbz_now) begin
                            state_q <= S_DONE;
                            hi_q    <= a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_last) begin
                        state_q <= S_FIX;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    state_q <= S_DONE;
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dbz_q   <= 1'b0;
                end
                default: begin
                    // start is ignored here: EX advances on this edge, so a held start is stale.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= mag(a, op[0]);
            opnd_q    <= mag(b, op[0]);
            is_div_q  <= op[1];
            neg_quo_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= op[0] & a[WIDTH-1];
        end else if (state_q == S_CALC) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign stall       = ((state_q == S_IDLE) && start && !dbz_now) || busy || (hilo_rd && busy);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed corner cases, reset abort and random operands.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hilo_rd;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, stall, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    res_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W), .ITERS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hilo_rd     (hilo_rd),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        longint      sx, sy, q, m;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dbz = 1'b0;
        r.hi  = '0;
        r.lo  = '0;
        if (o[1] && y == 32'd0) begin
            r.hi  = x;
            r.lo  = 32'hFFFF_FFFF;
            r.dbz = 1'b1;
        end else begin
            case (o)
                2'b00: p = {32'd0, x} * {32'd0, y};
                2'b01: begin q = sx * sy; p = 64'(q); end
                2'b10: p = {x % y, x / y};
                default: begin
                    q = sx / sy;
                    m = sx % sy;
                    p = {m[31:0], q[31:0]};
                end
            endcase
            r.hi = p[63:32];
            r.lo = p[31:0];
        end
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic directed, input logic [31:0] ehi, input logic [31:0] elo,
                          input int hl_from);
        res_t e, got;
        int   exp_cyc;
        if (directed) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dbz = o[1] && (y == 32'd0);
        end else begin
            e = model(o, x, y);
        end
        exp_cyc = e.dbz ? 1 : 34;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; hilo_rd = 1'b0;
        for (int cyc = 0; cyc <= exp_cyc + 2; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (hl_from >= 0 && cyc >= hl_from) hilo_rd = 1'b1;
            if (cyc == exp_cyc + 1) begin
                start   = 1'b0;
                hilo_rd = 1'b0;
            end
            #1;
            chk($sformatf("stall op%0d c%0d", o, cyc), stall, (!e.dbz && cyc <= 33));
            chk($sformatf("busy op%0d c%0d", o, cyc), busy, (!e.dbz && cyc >= 1 && cyc <= 33));
            chk($sformatf("done op%0d c%0d", o, cyc), done, (cyc == exp_cyc));
            chk($sformatf("dbz op%0d c%0d", o, cyc), div_by_zero, (e.dbz && cyc == exp_cyc));
            if (cyc == 5 && !e.dbz)
                chk("hold_prev_hilo", {hi, lo}, {last_hi, last_lo});
            if (done && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk($sformatf("hi op%0d a=%0h b=%0h", o, x, y), hi, got.hi);
                chk($sformatf("lo op%0d a=%0h b=%0h", o, x, y), lo, got.lo);
            end
            if (cyc == exp_cyc + 2)
                chk("hold_after_done", {hi, lo}, {e.hi, e.lo});
        end
        chk("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    task automatic reset_abort();
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = -32'sd1000; b = 32'd3; hilo_rd = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rstab_busy", busy, 0);
        chk("rstab_stall", stall, 0);
        chk("rstab_done", done, 0);
        chk("rstab_dbz", div_by_zero, 0);
        chk("rstab_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        #1;
        chk("rstab_idle", busy, 0);
        last_hi = '0;
        last_lo = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hilo_rd = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        run_op(OP_MULT,  -32'sd3, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3);
        run_op(OP_DIV,   -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b1, 32'd2, 32'd14, -1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, -1);
        run_op(OP_DIVU,  32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, -1);
        run_op(OP_DIV,   32'h8000_1234, 32'd0, 1'b1, 32'h8000_1234, 32'hFFFF_FFFF, 0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'd0, -1);
        reset_abort();
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 2);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if (i % 4 == 1) rb = rb & 32'h0000_00FF;
            run_op(ro, ra, rb, 1'b0, 32'd0, 32'd0, (i % 3 == 0) ? 4 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
